// File: rtl/hazard_detection_unit.sv
// Hazard detection for a classic 5-stage pipeline with branches resolved in ID.
// Detects load-use and branch-operand dependencies, generates stall/flush
// controls combinationally, and keeps stall/flush statistics plus a sticky
// watchdog flag for stall runs that last too long.
module hazard_detection_unit #(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_reg_rs,
  input  logic [4:0]       ID_reg_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_branch,
  input  logic             ID_branch_taken,
  input  logic             ID_jump,
  input  logic             EX_mem_read,
  input  logic             EX_reg_write,
  input  logic [4:0]       EX_reg_dst,
  input  logic             MEM_mem_read,
  input  logic [4:0]       MEM_reg_rd,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  // The run counter must be able to represent MAX_STALL+1 so the overrun is visible.
  localparam int CONSEC_RAW = $clog2(MAX_STALL + 2);
  localparam int CONSEC_W   = (CONSEC_RAW < 2) ? 2 : CONSEC_RAW;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CONSEC_W-1:0]   r_consec;
  logic [CONSEC_W-1:0]   w_consec_next;
  logic                  w_timeout_hit;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic                  r_timeout;

  logic w_ex_match;
  logic w_mem_match;
  logic w_load_use;
  logic w_br_dep;
  logic w_stall_req;
  logic w_redirect;

  // A producer register matches when it is nonzero and feeds a source of the ID instruction.
  function automatic logic src_match(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

  assign w_ex_match  = src_match(EX_reg_dst, ID_reg_rs, ID_reg_rt, ID_uses_rt);
  assign w_mem_match = src_match(MEM_reg_rd, ID_reg_rs, ID_reg_rt, ID_uses_rt);
  assign w_load_use  = EX_mem_read & w_ex_match;
  // Branches compare in ID, so they also wait for EX ALU results and for loads in MEM.
  assign w_br_dep    = ID_branch & ((EX_reg_write & w_ex_match) | (MEM_mem_read & w_mem_match));
  assign w_stall_req = w_load_use | w_br_dep;
  assign w_redirect  = ID_branch_taken | ID_jump;

  // Next state and pipeline controls; a stall outranks a redirect because the
  // branch operands are not valid yet, so the redirect is retried next cycle.
  always_comb begin
    w_state_next = RUN;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (w_stall_req) begin
      w_state_next = STALL;
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (w_redirect) begin
      w_state_next = FLUSH;
      IF_ID_flush  = 1'b1;
    end
  end

  // Consecutive-stall run length; a run entered from a non-stall state starts at one.
  always_comb begin
    w_consec_next = '0;
    w_timeout_hit = 1'b0;
    if (w_stall_req) begin
      if (r_state != STALL) begin
        w_consec_next = CONSEC_W'(1);
      end else if (r_consec == '1) begin
        w_consec_next = r_consec;
      end else begin
        w_consec_next = r_consec + 1'b1;
      end
      w_timeout_hit = (r_consec >= CONSEC_W'(MAX_STALL));
    end
  end

  // State register, run counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_consec  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_consec <= w_consec_next;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_req && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (IF_ID_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
  assign stall_timeout = r_timeout;

endmodule
